differential_decoder_serial: RTL and testbench

//   Streaming inverse of the differential word encoder. Accepts one differentially

---
 rtl/differential_decoder_serial.sv | 88 ++++++++
 tb/tb_differential_decoder_serial.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/differential_decoder_serial.sv
// Serial differential word decoder: rebuilds N 2-bit symbols from an encoded word
// as a running mod-4 sum, one symbol per clock, between two valid/ready handshakes.
module differential_decoder_serial #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] in_word,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_word,
  output logic           busy
);

  localparam int DATA_W = 2 * N;
  localparam int KW     = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic [DATA_W-1:0]  word;
  logic [1:0]         acc;
  logic [KW-1:0]      k;
  logic [1:0]         d_sym;
  logic [1:0]         s_sym;
  logic               last;

  // Two-bit add; the carry out is dropped by design, giving the mod-4 wrap.
  function automatic logic [1:0] add_mod4(input logic [1:0] a, input logic [1:0] b);
    return a + b;
  endfunction

  always_comb begin
    d_sym = 2'b00;
    for (int i = 0; i < N; i++) begin
      if (k == KW'(i)) d_sym = word[2*(N-1-i) +: 2];
    end
    s_sym = add_mod4(acc, d_sym);
    last  = (k == KW'(N - 1));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      word     <= '0;
      acc      <= 2'b00;
      k        <= '0;
      out_word <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            word <= in_word;
            acc  <= 2'b00;
            k    <= '0;
          end
        end
        RUN: begin
          acc <= s_sym;
          k   <= last ? '0 : k + KW'(1);
          // Only symbol k is written; the rest keep whatever they held.
          for (int i = 0; i < N; i++) begin
            if (k == KW'(i)) out_word[2*(N-1-i) +: 2] <= s_sym;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_differential_decoder_serial.sv
// Directed and random checks for differential_decoder_serial (N=8 and N=1 instances).
module tb_differential_decoder_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] in_word, out_word;
  logic        in_valid_1, in_ready_1, out_valid_1, out_ready_1, busy_1;
  logic [1:0]  in_word_1, out_word_1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  differential_decoder_serial #(.N(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .busy(busy)
  );

  differential_decoder_serial #(.N(1)) dut_1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_1), .in_ready(in_ready_1), .in_word(in_word_1),
    .out_valid(out_valid_1), .out_ready(out_ready_1), .out_word(out_word_1), .busy(busy_1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] encode(input logic [15:0] x);
    logic [15:0] d;
    logic [1:0]  prev, s;
    prev = 2'b00;
    d    = '0;
    for (int i = 0; i < 8; i++) begin
      s = x[15-2*i -: 2];
      d[15-2*i -: 2] = s - prev;
      prev = s;
    end
    return d;
  endfunction

  // Send one word, check latency and result, then complete the output handshake.
  task automatic run_word(input string tag, input logic [15:0] w, input logic [15:0] exp);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_word  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk({tag, "_latency"}, n, 32'd8);
    chk({tag, "_word"}, {16'd0, out_word}, {16'd0, exp});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] held, x;
    int          n;

    rst = 1'b1; in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
    in_valid_1 = 1'b0; in_word_1 = '0; out_ready_1 = 1'b0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_word", {16'd0, out_word}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Known word and wrap-around
    run_word("t1", 16'h9116, 16'hBC18);
    chk("t1_in_ready_after", {31'd0, in_ready}, 32'd1);
    run_word("t2", 16'h3FFF, 16'h3939);

    // Back-pressure in DONE
    in_word = 16'h9116; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    held = out_word;
    chk("t3_word", {16'd0, held}, 32'h0000BC18);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t3_hold_word", {16'd0, out_word}, {16'd0, held});
      chk("t3_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_in_ready_back", {31'd0, in_ready}, 32'd1);
    chk("t3_valid_drop", {31'd0, out_valid}, 32'd0);

    // Back-to-back with in_valid held high
    in_word = 16'h9116; in_valid = 1'b1;
    tick();
    in_word = 16'h3FFF;
    n = 0;
    while (!out_valid && n < 50) begin
      chk("t4_no_accept", {31'd0, in_ready}, 32'd0);
      tick(); n++;
    end
    chk("t4_lat1", n, 32'd8);
    chk("t4_word1", {16'd0, out_word}, 32'h0000BC18);
    tick();
    chk("t4_still_done", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t4_idle", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t4_busy2", {31'd0, busy}, 32'd1);
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk("t4_lat2", n, 32'd8);
    chk("t4_word2", {16'd0, out_word}, 32'h00003939);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset mid-RUN, with in_valid asserted alongside rst
    in_word = 16'h9116; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1; in_valid = 1'b1; in_word = 16'h3FFF;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_out_word", {16'd0, out_word}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_no_output", {31'd0, out_valid}, 32'd0);
    end
    run_word("t5_after", 16'h9116, 16'hBC18);

    // N=1 instance
    in_word_1 = 2'b10; in_valid_1 = 1'b1;
    tick();
    in_valid_1 = 1'b0;
    chk("t6_n1_busy", {31'd0, busy_1}, 32'd1);
    tick();
    chk("t6_n1_valid", {31'd0, out_valid_1}, 32'd1);
    chk("t6_n1_word", {30'd0, out_word_1}, 32'd2);
    out_ready_1 = 1'b1;
    tick();
    out_ready_1 = 1'b0;
    chk("t6_n1_in_ready", {31'd0, in_ready_1}, 32'd1);

    // Random round trip through the reference encoder
    for (int i = 0; i < 1000; i++) begin
      x = 16'($urandom);
      run_word("rnd", encode(x), x);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
